// File: rtl/scroll_display_ctrl_pkg.sv
// Shared constants for the scrolling hex message display: message ROM,
// 7-segment glyph table, blanking patterns and digit-to-anode mapping.
package scroll_display_ctrl_pkg;

    localparam int MSG_LEN_DEFAULT = 16;

    typedef logic [3:0] hex_t;
    typedef logic [6:0] glyph_t;

    // Blanking patterns for the active-low anodes and segments
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam glyph_t     SEG_OFF   = 7'b1111111;

    // Message ROM: entry i holds character code i (listed 15 down to 0)
    localparam logic [15:0][3:0] MSG_ROM = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
        4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
    };

    // Active-low {g,f,e,d,c,b,a} glyphs (listed F down to 0)
    localparam logic [15:0][6:0] GLYPHS = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Anode pattern per digit slot; digit 0 is the leftmost (an[3])
    localparam logic [3:0][3:0] DIGIT_ANODE = {
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

endpackage

// File: rtl/scroll_display_ctrl_seg7.sv
// Hex code to active-low 7-segment glyph decoder, purely combinational.
import scroll_display_ctrl_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = GLYPHS[code];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolls a 16-character hex message across a 4-digit multiplexed
// 7-segment display, advancing once per rising edge of a slow level.
import scroll_display_ctrl_pkg::*;

module scroll_display_ctrl #(
    parameter int MSG_LEN      = MSG_LEN_DEFAULT,
    parameter int REFRESH_BITS = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_src,
    input  logic       pause,
    input  logic       step,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [3:0] msg_ptr,
    output logic       advance
);

    localparam int CNT_W = REFRESH_BITS + 2;

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             primed;
    logic [1:0]       prime_cnt;
    logic             tick_edge;
    logic             do_adv;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit;
    logic             slot_zero;
    logic [4:0]       char_sum;
    logic [3:0]       char_idx;
    hex_t             char_code;
    glyph_t           glyph;

    // Bring the slow level into the clock domain and keep its previous value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= tick_src;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Ignore edges until the synchroniser pipeline holds real samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt <= 2'd0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_cnt == 2'd2) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign tick_edge = sync2 & ~prev & primed;
    assign do_adv    = (tick_edge & ~pause) | step;

    // Message pointer and the one-cycle advance strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_ptr <= 4'd0;
            advance <= 1'b0;
        end else begin
            advance <= do_adv;
            if (do_adv) begin
                msg_ptr <= (msg_ptr == 4'(MSG_LEN - 1)) ? 4'd0 : msg_ptr + 4'd1;
            end
        end
    end

    // Free-running refresh counter: top two bits pick the digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    assign digit     = refresh_cnt[CNT_W-1 -: 2];
    assign slot_zero = (refresh_cnt[REFRESH_BITS-1:0] == '0);
    assign char_sum  = {1'b0, msg_ptr} + {3'b000, digit};
    assign char_idx  = (char_sum >= 5'(MSG_LEN)) ? 4'(char_sum - 5'(MSG_LEN))
                                                  : char_sum[3:0];
    assign char_code = MSG_ROM[char_idx];

    hex_to_seg7 u_glyph (
        .code (char_code),
        .seg  (glyph)
    );

    // Registered display drive, blanked on the first position of each slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= ANODE_OFF;
            seg <= SEG_OFF;
        end else if (slot_zero) begin
            an  <= ANODE_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= DIGIT_ANODE[digit];
            seg <= glyph;
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench for scroll_display_ctrl using an advance scoreboard
// and a per-cycle display reference model.
module tb_scroll_display_ctrl;

    typedef struct {
        int ptr;
        int cyc;
    } adv_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_src = 1'b1;
    logic       pause    = 1'b0;
    logic       step     = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] msg_ptr;
    logic       advance;

    adv_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   exp_next  = 0;
    int   model_ptr = 0;
    int   disp_ptr  = 0;
    logic tick_drv  = 1'b1;

    logic [6:0] glyph_tb [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    scroll_display_ctrl #(
        .MSG_LEN      (16),
        .REFRESH_BITS (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_src (tick_src),
        .pause    (pause),
        .step     (step),
        .an       (an),
        .seg      (seg),
        .msg_ptr  (msg_ptr),
        .advance  (advance)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Count clock edges since the last reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue an expected advance unless one is already due in that cycle
    task automatic expectAdvance(input int c);
        if (sb_q.size() > 0 && sb_q[$].cyc == c) return;
        exp_next = (exp_next + 1) % 16;
        sb_q.push_back('{ptr: exp_next, cyc: c});
    endtask

    // Drive one cycle of inputs just after the clock edge and predict advances
    task automatic applyStimulus(input logic t, input logic s, input logic p);
        @(posedge clk);
        #1;
        if (t && !tick_drv && !p) expectAdvance(cyc + 3);
        if (s) expectAdvance(cyc + 1);
        tick_src = t;
        tick_drv = t;
        step     = s;
        pause    = p;
    endtask

    // Compare display and pointer each cycle against the reference model
    always @(negedge clk) begin
        int         c;
        int         d;
        logic [3:0] ea;
        logic [6:0] es;
        adv_t       e;
        if (reset) begin
            checkOutput("rst_an", {28'd0, an}, 32'hF);
            checkOutput("rst_seg", {25'd0, seg}, 32'h7F);
            checkOutput("rst_ptr", {28'd0, msg_ptr}, 32'd0);
            checkOutput("rst_adv", {31'd0, advance}, 32'd0);
            model_ptr = 0;
            disp_ptr  = 0;
        end else begin
            ea = 4'b1111;
            es = 7'b1111111;
            if (cyc > 0) begin
                c = (cyc - 1) % 16;
                d = c / 4;
                if ((c % 4) != 0) begin
                    ea[3 - d] = 1'b0;
                    es = glyph_tb[(disp_ptr + d) % 16];
                end
            end
            checkOutput("disp_an", {28'd0, an}, {28'd0, ea});
            checkOutput("disp_seg", {25'd0, seg}, {25'd0, es});
            if (advance) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexp_adv", {31'd0, advance}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("adv_cyc", cyc, e.cyc);
                    model_ptr = e.ptr;
                end
            end
            checkOutput("ptr", {28'd0, msg_ptr}, model_ptr);
            disp_ptr = model_ptr;
        end
    end

    initial begin
        // Tick already high at reset release must not advance
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("primed_hold_ptr", {28'd0, msg_ptr}, 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

        // Sixteen rising edges walk the pointer through a full wrap
        for (int i = 0; i < 16; i++) begin
            repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
            repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("wrap_ptr", {28'd0, msg_ptr}, 32'd0);

        // Paused tick edge is ignored
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pause_ptr", {28'd0, msg_ptr}, 32'd0);

        // Step landing in the same cycle as a tick edge gives one advance
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("coinc_ptr", {28'd0, msg_ptr}, 32'd1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

        // Steps bring the pointer to 7
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("step_ptr", {28'd0, msg_ptr}, 32'd7);

        // Reset mid-frame clears outputs before the next clock edge
        @(posedge clk);
        #1;
        reset    = 1'b1;
        sb_q.delete();
        exp_next = 0;
        #1;
        checkOutput("midrst_an", {28'd0, an}, 32'hF);
        checkOutput("midrst_seg", {25'd0, seg}, 32'h7F);
        checkOutput("midrst_ptr", {28'd0, msg_ptr}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_ptr", {28'd0, msg_ptr}, 32'd1);

        // Drain any outstanding expectations within a bounded wait
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
